// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage: ALU opcodes, FSM states,
// condition flags and the default multiplier iteration count.
package exec_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } exec_state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam int MUL_CYCLES_DEFAULT = 32;

  function automatic flags_t make_flags(logic [31:0] r, logic c, logic v);
    flags_t f;
    f.n = r[31];
    f.z = (r == 32'd0);
    f.c = c;
    f.v = v;
    return f;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier datapath; one partial product per step.
// product_o already includes the current step, so the last step's sum is usable directly.
module mul_iter (
  input  logic        clk,
  input  logic        start_i,
  input  logic        step_i,
  input  logic        last_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        done_o,
  output logic [31:0] product_o
);

  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_step;

  assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
  assign product_o = acc_step;
  assign done_o    = step_i & last_i;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start_i) begin
      acc_d    = 32'd0;
      mcand_d  = a_i;
      mplier_d = b_i;
    end else if (step_i) begin
      acc_d    = acc_step;
      mcand_d  = {mcand_q[30:0], 1'b0};
      mplier_d = {1'b0, mplier_q[31:1]};
    end
  end

  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU plus a multi-cycle MUL that stalls upstream
// while the shift-add multiplier iterates; results and controls are registered.
module exec_stage
  import exec_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  input  logic [31:0] IMMEXTEND,
  input  logic [2:0]  ALUSIGNAL,
  input  logic        OPBSELECT,
  input  logic        WE,
  input  logic        SELECTMEM,
  input  logic        DATAINPUTS,
  input  logic        DATAINPUTON,
  input  logic        FLUSH,
  output logic [31:0] ALURESULT,
  output logic [31:0] WRITEDATA,
  output logic [3:0]  FLAGS,
  output logic        WE_M,
  output logic        SELECTMEM_M,
  output logic        DATAINPUTS_M,
  output logic        DATAINPUTON_M,
  output logic        STALL
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  function automatic logic add_ovf(logic signed [31:0] a, logic signed [31:0] b,
                                   logic signed [31:0] s);
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

  function automatic logic sub_ovf(logic signed [31:0] a, logic signed [31:0] b,
                                   logic signed [31:0] s);
    return (a[31] != b[31]) && (s[31] != a[31]);
  endfunction

  exec_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      res_q, res_d;
  logic [31:0]      wdata_q, wdata_d;
  flags_t           flags_q, flags_d;
  logic [3:0]       ctrlm_q, ctrlm_d;
  logic [3:0]       ctrl_cap_q, ctrl_cap_d;
  logic [31:0]      wdata_cap_q, wdata_cap_d;

  alu_op_e     op;
  logic [31:0] op_b;
  logic [3:0]  ctrl_in;
  logic [31:0] alu_res;
  logic        alu_c, alu_v;
  logic [32:0] wide;
  logic        mul_start, mul_step, mul_last, mul_done;
  logic [31:0] mul_prod;

  assign op       = alu_op_e'(ALUSIGNAL);
  assign op_b     = OPBSELECT ? IMMEXTEND : DATA2;
  assign ctrl_in  = {WE, SELECTMEM, DATAINPUTS, DATAINPUTON};
  assign mul_last = (cnt_q == CNT_LAST);

  always_comb begin
    alu_res = 32'd0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    wide    = 33'd0;
    case (op)
      OP_ADD: begin
        wide    = {1'b0, DATA1} + {1'b0, op_b};
        alu_res = wide[31:0];
        alu_c   = wide[32];
        alu_v   = add_ovf(DATA1, op_b, wide[31:0]);
      end
      OP_SUB: begin
        // Carry out of a + ~b + 1 is the no-borrow bit.
        wide    = {1'b0, DATA1} + {1'b0, ~op_b} + 33'd1;
        alu_res = wide[31:0];
        alu_c   = wide[32];
        alu_v   = sub_ovf(DATA1, op_b, wide[31:0]);
      end
      OP_AND:  alu_res = DATA1 & op_b;
      OP_OR:   alu_res = DATA1 | op_b;
      OP_XOR:  alu_res = DATA1 ^ op_b;
      OP_SLL:  alu_res = DATA1 << op_b[4:0];
      OP_SRL:  alu_res = DATA1 >> op_b[4:0];
      default: alu_res = 32'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    wdata_d     = wdata_q;
    flags_d     = flags_q;
    ctrlm_d     = ctrlm_q;
    ctrl_cap_d  = ctrl_cap_q;
    wdata_cap_d = wdata_cap_q;
    mul_start   = 1'b0;
    mul_step    = 1'b0;
    STALL       = 1'b0;
    if (state_q == ST_IDLE) begin
      if (FLUSH) begin
        res_d   = 32'd0;
        wdata_d = 32'd0;
        flags_d = '0;
        ctrlm_d = 4'd0;
      end else if (op == OP_MUL) begin
        STALL       = 1'b1;
        mul_start   = 1'b1;
        cnt_d       = '0;
        state_d     = ST_BUSY;
        ctrl_cap_d  = ctrl_in;
        wdata_cap_d = DATA2;
        ctrlm_d     = 4'd0;
      end else begin
        res_d   = alu_res;
        wdata_d = DATA2;
        flags_d = make_flags(alu_res, alu_c, alu_v);
        ctrlm_d = ctrl_in;
      end
    end else begin
      // FLUSH is deliberately ignored here: the in-flight MUL always completes.
      mul_step = 1'b1;
      STALL    = ~mul_last;
      ctrlm_d  = 4'd0;
      cnt_d    = cnt_q + CNT_W'(1);
      if (mul_done) begin
        res_d   = mul_prod;
        wdata_d = wdata_cap_q;
        flags_d = make_flags(mul_prod, 1'b0, 1'b0);
        ctrlm_d = ctrl_cap_q;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    end
    if (reset) STALL = 1'b0;
  end

  mul_iter u_mul (
    .clk       (clk),
    .start_i   (mul_start),
    .step_i    (mul_step),
    .last_i    (mul_last),
    .a_i       (DATA1),
    .b_i       (op_b),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      res_q   <= 32'd0;
      wdata_q <= 32'd0;
      flags_q <= '0;
      ctrlm_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      wdata_q <= wdata_d;
      flags_q <= flags_d;
      ctrlm_q <= ctrlm_d;
    end
  end

  always_ff @(posedge clk) begin
    ctrl_cap_q  <= ctrl_cap_d;
    wdata_cap_q <= wdata_cap_d;
  end

  assign ALURESULT     = res_q;
  assign WRITEDATA     = wdata_q;
  assign FLAGS         = flags_q;
  assign WE_M          = ctrlm_q[3];
  assign SELECTMEM_M   = ctrlm_q[2];
  assign DATAINPUTS_M  = ctrlm_q[1];
  assign DATAINPUTON_M = ctrlm_q[0];

endmodule

// File: tb/tb_exec_stage.sv
// Directed and randomized bench for exec_stage with an arithmetic reference model.
module tb_exec_stage;

  localparam int NCYC = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] DATA1, DATA2, IMMEXTEND;
  logic [2:0]  ALUSIGNAL;
  logic        OPBSELECT, WE, SELECTMEM, DATAINPUTS, DATAINPUTON, FLUSH;
  logic [31:0] ALURESULT, WRITEDATA;
  logic [3:0]  FLAGS;
  logic        WE_M, SELECTMEM_M, DATAINPUTS_M, DATAINPUTON_M, STALL;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_res, exp_wd;
  logic [3:0]  exp_fl, exp_ctl;

  always #5 clk = ~clk;

  exec_stage #(.MUL_CYCLES(NCYC)) dut (
    .clk(clk), .reset(reset), .DATA1(DATA1), .DATA2(DATA2), .IMMEXTEND(IMMEXTEND),
    .ALUSIGNAL(ALUSIGNAL), .OPBSELECT(OPBSELECT), .WE(WE), .SELECTMEM(SELECTMEM),
    .DATAINPUTS(DATAINPUTS), .DATAINPUTON(DATAINPUTON), .FLUSH(FLUSH),
    .ALURESULT(ALURESULT), .WRITEDATA(WRITEDATA), .FLAGS(FLAGS), .WE_M(WE_M),
    .SELECTMEM_M(SELECTMEM_M), .DATAINPUTS_M(DATAINPUTS_M), .DATAINPUTON_M(DATAINPUTON_M),
    .STALL(STALL)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_res"}, ALURESULT, exp_res);
    chk({tag, "_wd"}, WRITEDATA, exp_wd);
    chk({tag, "_flags"}, {28'd0, FLAGS}, {28'd0, exp_fl});
    chk({tag, "_ctl"}, {28'd0, WE_M, SELECTMEM_M, DATAINPUTS_M, DATAINPUTON_M}, {28'd0, exp_ctl});
  endtask

  // Reference ALU written from the arithmetic definitions: {N,Z,C,V}.
  task automatic ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [3:0] f);
    longint sa, sb, sr;
    logic [32:0] wide;
    logic [63:0] p;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[31:0];
        c = wide[32];
        sr = sa + sb;
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd1: begin
        r = a - b;
        c = (a >= b);
        sr = sa - sb;
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[4:0];
      3'd6: r = a >> b[4:0];
      default: begin
        p = {32'd0, a} * {32'd0, b};
        r = p[31:0];
      end
    endcase
    f = {r[31], (r == 32'd0), c, v};
  endtask

  // Called at a negative edge; returns at the following negative edge.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic opb,
                       input logic [3:0] ctl, input logic flush);
    logic [31:0] r;
    logic [3:0]  f;
    DATA1 = a; DATA2 = b; IMMEXTEND = imm; ALUSIGNAL = op; OPBSELECT = opb;
    {WE, SELECTMEM, DATAINPUTS, DATAINPUTON} = ctl; FLUSH = flush;
    #1;
    chk({tag, "_stall"}, {31'd0, STALL}, 32'd0);
    if (flush) begin
      exp_res = 32'd0; exp_wd = 32'd0; exp_fl = 4'd0; exp_ctl = 4'd0;
    end else begin
      ref_alu(op, a, opb ? imm : b, r, f);
      exp_res = r; exp_wd = b; exp_fl = f; exp_ctl = ctl;
    end
    @(posedge clk); #1;
    check_all(tag);
    @(negedge clk);
  endtask

  // Called at a negative edge; returns at the negative edge after the result appears.
  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] ctl, input bit scramble);
    logic [31:0] r;
    logic [3:0]  f;
    ref_alu(3'd7, a, b, r, f);
    DATA1 = a; DATA2 = b; IMMEXTEND = $urandom; ALUSIGNAL = 3'd7; OPBSELECT = 1'b0;
    {WE, SELECTMEM, DATAINPUTS, DATAINPUTON} = ctl; FLUSH = 1'b0;
    for (int c = 1; c <= NCYC + 1; c++) begin
      #1;
      chk({tag, "_stall"}, {31'd0, STALL}, {31'd0, (c <= NCYC)});
      @(posedge clk); #1;
      if (c <= NCYC) begin
        chk({tag, "_busy_ctl"}, {28'd0, WE_M, SELECTMEM_M, DATAINPUTS_M, DATAINPUTON_M}, 32'd0);
        if (c >= 2) begin
          chk({tag, "_busy_res"}, ALURESULT, exp_res);
          chk({tag, "_busy_wd"}, WRITEDATA, exp_wd);
          chk({tag, "_busy_fl"}, {28'd0, FLAGS}, {28'd0, exp_fl});
        end
        @(negedge clk);
        if (scramble) begin
          FLUSH = 1'($urandom);
          DATA1 = $urandom;
          DATA2 = $urandom;
          {WE, SELECTMEM, DATAINPUTS, DATAINPUTON} = 4'($urandom);
        end
      end
    end
    exp_res = r; exp_wd = b; exp_fl = f; exp_ctl = ctl;
    check_all(tag);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b, imm;
    reset = 1'b1;
    DATA1 = '0; DATA2 = '0; IMMEXTEND = '0; ALUSIGNAL = '0; OPBSELECT = 1'b0;
    WE = 1'b0; SELECTMEM = 1'b0; DATAINPUTS = 1'b0; DATAINPUTON = 1'b0; FLUSH = 1'b0;
    exp_res = '0; exp_wd = '0; exp_fl = '0; exp_ctl = '0;
    repeat (2) @(posedge clk);

    // Reset dominates a MUL request and keeps STALL low.
    @(negedge clk);
    ALUSIGNAL = 3'd7; DATA1 = 32'h1234; DATA2 = 32'h55; WE = 1'b1;
    #1;
    chk("rst_stall", {31'd0, STALL}, 32'd0);
    @(posedge clk); #1;
    check_all("rst");
    @(negedge clk);
    reset = 1'b0;

    do_op("add_ovf", 3'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 4'b1000, 1'b0);
    do_op("sub_imm", 3'd1, 32'd5, 32'd9, 32'd5, 1'b1, 4'b0100, 1'b0);
    do_op("bubble", 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0000, 1'b0);
    do_op("sub_borrow", 3'd1, 32'd3, 32'd7, 32'd0, 1'b0, 4'b0011, 1'b0);
    do_op("sub_ovf", 3'd1, 32'h80000000, 32'd1, 32'd0, 1'b0, 4'b1111, 1'b0);
    do_op("srl31", 3'd6, 32'h80000000, 32'd31, 32'd0, 1'b0, 4'b0001, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 6));
      a   = $urandom;
      b   = $urandom;
      imm = $urandom;
      do_op("rand", op, a, b, imm, 1'($urandom), 4'($urandom), 1'b0);
    end

    do_mul("mul_dir", 32'h00010003, 32'h00020005, 4'b1000, 1'b0);
    do_op("after_mul", 3'd0, 32'd1, 32'd1, 32'd0, 1'b0, 4'b0000, 1'b0);
    chk("mul_dir_value", 32'h000B000F, 32'h00010003 * 32'h00020005);

    do_mul("mul_flush", $urandom, $urandom, 4'($urandom), 1'b1);
    for (int i = 0; i < 3; i++) begin
      do_mul("mul_rand", $urandom, $urandom, 4'($urandom), 1'b1);
      do_op("post_mul", 3'($urandom_range(0, 6)), $urandom, $urandom, $urandom, 1'b0, 4'($urandom), 1'b0);
    end

    // Flush in IDLE: bubble, no MUL start.
    do_op("flush_sll", 3'd5, 32'd1, 32'd4, 32'd0, 1'b0, 4'b1000, 1'b1);
    do_op("flush_mul", 3'd7, 32'd6, 32'd7, 32'd0, 1'b0, 4'b1111, 1'b1);
    do_op("after_flush", 3'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 1'b0, 4'b0110, 1'b0);

    // Reset while BUSY aborts the multiply.
    DATA1 = 32'd77; DATA2 = 32'd99; ALUSIGNAL = 3'd7; OPBSELECT = 1'b0;
    {WE, SELECTMEM, DATAINPUTS, DATAINPUTON} = 4'b1111; FLUSH = 1'b0;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("busy_stall", {31'd0, STALL}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_busy_stall", {31'd0, STALL}, 32'd0);
    @(posedge clk); #1;
    exp_res = '0; exp_wd = '0; exp_fl = '0; exp_ctl = '0;
    check_all("rst_busy");
    @(negedge clk);
    reset = 1'b0;
    do_op("add_after_rst", 3'd0, 32'd2, 32'd3, 32'd0, 1'b0, 4'b1000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
